// File: rtl/xgmii_pkg.sv
// Shared XGMII/GMII control-character constants, lane-decode state and the
// 72-bit XGMII word type used by the packer and the unpacker.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE    = 8'h07;
  localparam logic [7:0] XGMII_START   = 8'hFB;
  localparam logic [7:0] XGMII_TERM    = 8'hFD;
  localparam logic [7:0] XGMII_ERROR   = 8'hFE;
  localparam logic [7:0] GMII_PREAMBLE = 8'h55;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } xgmii_word_t;

endpackage

// File: rtl/xgmii_lane_decode.sv
// Combinational per-byte XGMII-to-GMII decode: maps (state, c, d) to the GMII
// byte, next frame state and end-of-frame events; no latency, no flow control.
module xgmii_lane_decode
  import xgmii_pkg::*;
(
  input  state_e     state,
  input  logic       c,
  input  logic [7:0] d,
  output logic       en,
  output logic       er,
  output logic [7:0] dat,
  output state_e     state_nxt,
  output logic       frame_done,
  output logic       err_done
);

  always_comb begin
    en         = 1'b0;
    er         = 1'b0;
    dat        = 8'h00;
    state_nxt  = state;
    frame_done = 1'b0;
    err_done   = 1'b0;
    case (state)
      IDLE: begin
        // /S/ occupies the SFD-less first preamble octet on GMII.
        if (c && d == XGMII_START) begin
          en        = 1'b1;
          dat       = GMII_PREAMBLE;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (!c) begin
          en  = 1'b1;
          dat = d;
        end else if (d == XGMII_TERM) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          en        = 1'b1;
          er        = 1'b1;
          dat       = d;
          state_nxt = ERR;
        end
      end
      ERR: begin
        if (c && d == XGMII_TERM) begin
          err_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          en  = 1'b1;
          er  = 1'b1;
          dat = d;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/xgmii64_to_gmii8.sv
// 64-bit XGMII word stream to 8-bit GMII bytes, lane 0 first, one word per 8 cycles.
// Lane 0 is registered onto GMII one cycle after the word is held; in_ready stalls while lanes 0-6 drain.
module xgmii64_to_gmii8
  import xgmii_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             xgmii_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_c,
  input  logic [63:0]      in_d,
  output logic             gmii_en,
  output logic             gmii_er,
  output logic [7:0]       gmii_d,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  xgmii_word_t      hold_q, hold_d;
  logic             loaded_q, loaded_d;
  logic [2:0]       lane_q, lane_d;
  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             gmii_en_q, gmii_en_d;
  logic             gmii_er_q, gmii_er_d;
  logic [7:0]       gmii_d_q, gmii_d_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       accept;
  logic       cur_c;
  logic [7:0] cur_d;
  logic       dec_en, dec_er, dec_frame_done, dec_err_done;
  logic [7:0] dec_dat;
  state_e     dec_state_nxt;

  assign cur_c = hold_q.c[lane_q];
  assign cur_d = hold_q.d[{lane_q, 3'b000} +: 8];

  xgmii_lane_decode u_decode (
    .state      (state_q),
    .c          (cur_c),
    .d          (cur_d),
    .en         (dec_en),
    .er         (dec_er),
    .dat        (dec_dat),
    .state_nxt  (dec_state_nxt),
    .frame_done (dec_frame_done),
    .err_done   (dec_err_done)
  );

  always_comb begin
    accept      = in_valid && in_ready_q;
    hold_d      = hold_q;
    loaded_d    = loaded_q;
    lane_d      = lane_q;
    state_d     = state_q;
    gmii_en_d   = 1'b0;
    gmii_er_d   = 1'b0;
    gmii_d_d    = 8'h00;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (loaded_q) begin
      gmii_en_d = dec_en;
      gmii_er_d = dec_er;
      gmii_d_d  = dec_dat;
      state_d   = dec_state_nxt;
      lane_d    = lane_q + 3'd1;
      if (lane_q == 3'd7) loaded_d = 1'b0;
      if (dec_frame_done && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
      if (dec_err_done && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end else if (state_q != IDLE) begin
      // Starved mid-frame: the frame can no longer be delivered intact.
      gmii_en_d = 1'b1;
      gmii_er_d = 1'b1;
      state_d   = ERR;
    end

    if (accept) begin
      hold_d.c = in_c;
      hold_d.d = in_d;
      lane_d   = 3'd0;
      loaded_d = 1'b1;
    end

    in_ready_d = !loaded_d || (lane_d == 3'd7);
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q      <= '0;
      loaded_q    <= 1'b0;
      lane_q      <= 3'd0;
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      gmii_en_q   <= 1'b0;
      gmii_er_q   <= 1'b0;
      gmii_d_q    <= 8'h00;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      hold_q      <= hold_d;
      loaded_q    <= loaded_d;
      lane_q      <= lane_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      gmii_en_q   <= gmii_en_d;
      gmii_er_q   <= gmii_er_d;
      gmii_d_q    <= gmii_d_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign gmii_en   = gmii_en_q;
  assign gmii_er   = gmii_er_q;
  assign gmii_d    = gmii_d_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
